layer_compositor: RTL and testbench

Parametrised, pipelined pixel compositor that merges NUM_LAYERS layer colours plus a background into the single OLED pixel stream, replacing the hand-written priority mux in the game top level. It also measures per-frame pixel overlap between two chosen layers, giving a pixel-accurate hit signal for health management. It sits between the sprite, status-bar and background renderers and the OLED driver, on the fast system clock.

---
 rtl/layer_compositor.sv | 125 ++++++++++++
 tb/tb_layer_compositor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - two-stage layer priority compositor with per-frame overlap counter
// Optional macro LAYER_COMPOSITOR_OVERLAP_EN enables the overlap counter; otherwise overlap outputs are tied to 0.
module layer_compositor #(
  parameter int                 NUM_LAYERS  = 4,
  parameter int                 COLOR_W     = 16,
  parameter int                 PIX_W       = 13,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 16'h0000,
  parameter int                 OVL_A       = 1,
  parameter int                 OVL_B       = 2,
  parameter int                 CNT_W       = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_begin,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pixel_index,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_col,
  input  logic [NUM_LAYERS-1:0]         layer_en_req,
  input  logic [COLOR_W-1:0]            bg_col,
  output logic [COLOR_W-1:0]            pixel_data,
  output logic [PIX_W-1:0]              pixel_index_out,
  output logic                          pixel_out_valid,
  output logic                          overlap_flag,
  output logic [CNT_W-1:0]              overlap_count
);

  logic [NUM_LAYERS-1:0]         r_layer_en_active;
  logic                          r_s1_valid;
  logic [NUM_LAYERS*COLOR_W-1:0] r_s1_col;
  logic [COLOR_W-1:0]            r_s1_bg;
  logic [PIX_W-1:0]              r_s1_idx;
  logic [COLOR_W-1:0]            r_pixel_data;
  logic [PIX_W-1:0]              r_pixel_index_out;
  logic                          r_pixel_out_valid;
  logic [COLOR_W-1:0]            w_sel_col;

  // Enables only change at frame boundaries so a frame is never composed with mixed settings.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_layer_en_active <= '1;
    end else if (frame_begin) begin
      r_layer_en_active <= layer_en_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_col   <= '0;
      r_s1_bg    <= '0;
      r_s1_idx   <= '0;
    end else begin
      r_s1_valid <= pix_valid;
      if (pix_valid) begin
        r_s1_col <= layer_col;
        r_s1_bg  <= bg_col;
        r_s1_idx <= pixel_index;
      end
    end
  end

  // Walk from lowest priority upward so the lowest visible index is the last assignment.
  always_comb begin
    w_sel_col = r_s1_bg;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_layer_en_active[i] && (r_s1_col[i*COLOR_W +: COLOR_W] != TRANSPARENT)) begin
        w_sel_col = r_s1_col[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_data      <= '0;
      r_pixel_index_out <= '0;
      r_pixel_out_valid <= 1'b0;
    end else begin
      r_pixel_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_pixel_data      <= w_sel_col;
        r_pixel_index_out <= r_s1_idx;
      end
    end
  end

  assign pixel_data      = r_pixel_data;
  assign pixel_index_out = r_pixel_index_out;
  assign pixel_out_valid = r_pixel_out_valid;

`ifdef LAYER_COMPOSITOR_OVERLAP_EN
  logic             w_ovl_hit;
  logic [CNT_W-1:0] w_ovl_next;
  logic [CNT_W-1:0] r_ovl_cnt;
  logic [CNT_W-1:0] r_overlap_count;
  logic             r_overlap_flag;

  // Overlap ignores priority: a pixel hidden by a higher layer still counts.
  assign w_ovl_hit = r_s1_valid
                  && r_layer_en_active[OVL_A] && r_layer_en_active[OVL_B]
                  && (r_s1_col[OVL_A*COLOR_W +: COLOR_W] != TRANSPARENT)
                  && (r_s1_col[OVL_B*COLOR_W +: COLOR_W] != TRANSPARENT);
  assign w_ovl_next = (w_ovl_hit && (r_ovl_cnt != {CNT_W{1'b1}})) ? r_ovl_cnt + 1'b1 : r_ovl_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovl_cnt       <= '0;
      r_overlap_count <= '0;
      r_overlap_flag  <= 1'b0;
    end else if (frame_begin) begin
      r_overlap_count <= w_ovl_next;
      r_overlap_flag  <= (w_ovl_next != '0);
      r_ovl_cnt       <= '0;
    end else begin
      r_ovl_cnt <= w_ovl_next;
    end
  end

  assign overlap_count = r_overlap_count;
  assign overlap_flag  = r_overlap_flag;
`else
  assign overlap_count = '0;
  assign overlap_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor (default and CNT_W=4 instances)
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic        pix_valid;
  logic [12:0] pixel_index;
  logic [63:0] layer_col;
  logic [3:0]  layer_en_req;
  logic [15:0] bg_col;
  logic [15:0] pixel_data, pixel_data4;
  logic [12:0] pixel_index_out, pixel_index_out4;
  logic        pixel_out_valid, pixel_out_valid4;
  logic        overlap_flag, overlap_flag4;
  logic [11:0] overlap_count;
  logic [3:0]  overlap_count4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] col;
    logic [12:0] idx;
    int          due;
  } exp_t;
  exp_t q[$];

  logic [3:0] m_en;
  int         m_cnt;
  int         m_prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_compositor dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .pix_valid(pix_valid),
    .pixel_index(pixel_index), .layer_col(layer_col), .layer_en_req(layer_en_req),
    .bg_col(bg_col), .pixel_data(pixel_data), .pixel_index_out(pixel_index_out),
    .pixel_out_valid(pixel_out_valid), .overlap_flag(overlap_flag), .overlap_count(overlap_count)
  );

  layer_compositor #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .pix_valid(pix_valid),
    .pixel_index(pixel_index), .layer_col(layer_col), .layer_en_req(layer_en_req),
    .bg_col(bg_col), .pixel_data(pixel_data4), .pixel_index_out(pixel_index_out4),
    .pixel_out_valid(pixel_out_valid4), .overlap_flag(overlap_flag4), .overlap_count(overlap_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sel(input logic [63:0] c, input logic [15:0] bg, input logic [3:0] en);
    logic [15:0] r;
    r = bg;
    for (int i = 3; i >= 0; i--) begin
      if (en[i] && (c[i*16 +: 16] != 16'h0000)) r = c[i*16 +: 16];
    end
    return r;
  endfunction

  function automatic bit model_hit(input logic [63:0] c, input logic [3:0] en);
    return en[1] && en[2] && (c[31:16] != 16'h0000) && (c[47:32] != 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame();
    m_prev = m_cnt;
    m_cnt  = 0;
    m_en   = layer_en_req;
  endtask

  task automatic send(input logic [12:0] idx, input logic [63:0] cols, input logic [15:0] bg, input logic fb);
    exp_t e;
    pix_valid   = 1'b1;
    pixel_index = idx;
    layer_col   = cols;
    bg_col      = bg;
    frame_begin = fb;
    if (fb) model_frame();
    if (model_hit(cols, m_en)) m_cnt++;
    e.col = model_sel(cols, bg, m_en);
    e.idx = idx;
    e.due = cyc + 2;
    q.push_back(e);
    tick();
    pix_valid   = 1'b0;
    frame_begin = 1'b0;
  endtask

  task automatic frame();
    frame_begin = 1'b1;
    model_frame();
    tick();
    frame_begin = 1'b0;
  endtask

  task automatic chk_ovl(input string tag);
    int sat;
    sat = (m_prev > 15) ? 15 : m_prev;
`ifdef LAYER_COMPOSITOR_OVERLAP_EN
    chk({tag, "_count"}, 32'(overlap_count), 32'(m_prev));
    chk({tag, "_flag"}, 32'(overlap_flag), 32'(m_prev != 0));
    chk({tag, "_count4"}, 32'(overlap_count4), 32'(sat));
`else
    chk({tag, "_count"}, 32'(overlap_count), 32'(0));
    chk({tag, "_flag"}, 32'(overlap_flag), 32'(0));
    chk({tag, "_count4"}, 32'(overlap_count4), 32'(sat & 0));
`endif
  endtask

  // Scoreboard: every output pixel must match the oldest expected entry at exactly its due cycle.
  always @(negedge clk) begin
    if (!reset && pixel_out_valid) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_pixel", 32'(pixel_index_out), 32'h1fff_ffff);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_data", 32'(pixel_data), 32'(e.col));
        chk("sb_index", 32'(pixel_index_out), 32'(e.idx));
        chk("sb_latency", 32'(cyc), 32'(e.due));
        chk("sb_data4", 32'(pixel_data4), 32'(e.col));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] C_PRIO = {16'h0000, 16'h07E0, 16'hF800, 16'h0000};
  localparam logic [63:0] C_ONLY1 = {16'h0000, 16'h0000, 16'h1234, 16'h0000};
  localparam logic [63:0] C_HIDDEN = {16'h0000, 16'h0F0F, 16'hAAAA, 16'h5555};

  initial begin
    reset = 1'b1; frame_begin = 1'b0; pix_valid = 1'b0; pixel_index = '0;
    layer_col = '0; layer_en_req = 4'b1111; bg_col = '0;
    m_en = 4'b1111; m_cnt = 0; m_prev = 0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_pixel_data", 32'(pixel_data), 0);
    chk("rst_index_out", 32'(pixel_index_out), 0);
    chk("rst_out_valid", 32'(pixel_out_valid), 0);
    chk_ovl("rst");

    // Priority, background fallback, hidden layers and a bottom-layer-only case.
    send(13'd100, C_PRIO, 16'h001F, 1'b0);
    send(13'd101, 64'h0, 16'h001F, 1'b0);
    send(13'd102, C_HIDDEN, 16'h001F, 1'b0);
    send(13'd8191, {16'hBEEF, 48'h0}, 16'h0001, 1'b0);
    repeat (3) tick();

    // Mid-frame enable request must not take effect until frame_begin.
    layer_en_req = 4'b1101;
    send(13'd200, C_PRIO, 16'h001F, 1'b0);
    repeat (2) tick();
    frame();
    send(13'd201, C_PRIO, 16'h001F, 1'b0);
    repeat (2) tick();
    layer_en_req = 4'b1111;
    frame();
    repeat (2) tick();

    // 37 overlaps mixed with non-overlapping pixels; also exercises CNT_W=4 saturation.
    for (int i = 0; i < 37; i++) begin
      send(13'(300 + i), (i % 3 == 0) ? C_HIDDEN : C_PRIO, 16'h001F, 1'b0);
      if (i % 5 == 0) send(13'(400 + i), C_ONLY1, 16'h001F, 1'b0);
    end
    frame();
    chk_ovl("ovl37");
    for (int i = 0; i < 10; i++) send(13'(500 + i), C_ONLY1, 16'h0000, 1'b0);
    frame();
    chk_ovl("ovl0");

    for (int i = 0; i < 20; i++) send(13'(600 + i), C_PRIO, 16'h0000, 1'b0);
    frame();
    chk_ovl("ovl20");

    // Overlapping pixel on the frame_begin cycle belongs to the new frame.
    for (int i = 0; i < 5; i++) send(13'(700 + i), C_PRIO, 16'h0000, 1'b0);
    send(13'd710, C_PRIO, 16'h0000, 1'b1);
    chk_ovl("simul_old");
    repeat (2) tick();
    frame();
    chk_ovl("simul_new");

    // Disabled layer 1: overlap must not count.
    layer_en_req = 4'b1101;
    frame();
    for (int i = 0; i < 4; i++) send(13'(800 + i), C_PRIO, 16'h0000, 1'b0);
    layer_en_req = 4'b1111;
    frame();
    chk_ovl("disabled");

    // Reset while streaming: in-flight pixels are dropped and counting restarts.
    for (int i = 0; i < 6; i++) send(13'(900 + i), C_PRIO, 16'h0000, 1'b0);
    reset = 1'b1;
    pix_valid = 1'b1;
    layer_col = C_PRIO;
    tick();
    tick();
    q.delete();
    m_en = 4'b1111; m_cnt = 0; m_prev = 0;
    reset = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("rst_flush_c1", 32'(pixel_out_valid), 0);
    @(negedge clk);
    chk("rst_flush_c2", 32'(pixel_out_valid), 0);
    chk_ovl("rst_mid");
    tick();
    for (int i = 0; i < 3; i++) send(13'(1000 + i), C_PRIO, 16'h0000, 1'b0);
    frame();
    chk_ovl("post_rst");

    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("sb_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
